// File: rtl/trap_ctrl_unit_pkg.sv
// rtl/trap_ctrl_unit_pkg.sv - shared states, PC-select encodings and trap cause codes
package trap_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULTI = 2'd1,
        ST_SLEEP = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [1:0] PC_BRANCH_JUMP = 2'd0;
    localparam logic [1:0] PC_EPC         = 2'd1;
    localparam logic [1:0] PC_EXCEPTION   = 2'd2;

    localparam logic [4:0] CAUSE_ECALL        = 5'd1;
    localparam logic [4:0] CAUSE_ILLEGAL      = 5'd2;
    localparam logic [4:0] CAUSE_IRQ          = 5'd3;
    localparam logic [4:0] CAUSE_LSU_ERR      = 5'd4;
    localparam logic [4:0] CAUSE_TIMEOUT      = 5'd5;
    localparam logic [4:0] CAUSE_IRQ_VEC_BASE = 5'd8;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - interrupt priority encoder, lowest set index wins
module irq_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl_unit.sv
// rtl/trap_ctrl_unit.sv - issue/trap sequencer between decode and PC-select
module trap_ctrl_unit
    import trap_ctrl_unit_pkg::*;
#(
    parameter int                    NUM_IRQ    = 8,
    parameter int                    CNT_W      = 4,
    parameter int                    TIMEOUT    = 15,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] TRAP_BASE  = '0,
    parameter bit                    VECTORED   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_valid_i,
    input  logic                  jump_inst_i,
    input  logic                  branch_inst_i,
    input  logic                  comp_result_i,
    input  logic                  ecall_inst_i,
    input  logic                  ebreak_inst_i,
    input  logic                  mret_inst_i,
    input  logic                  wfi_inst_i,
    input  logic                  illegal_inst_i,
    input  logic [NUM_IRQ-1:0]    irq_i,
    input  logic [NUM_IRQ-1:0]    irq_mask_i,
    input  logic                  irq_gie_i,
    input  logic                  lsu_en_i,
    input  logic                  lsu_done_i,
    input  logic                  lsu_err_i,
    input  logic                  mc_en_i,
    input  logic                  mc_done_i,
    output logic [CNT_W-1:0]      cycle_counter_o,
    output logic                  deassert_rf_wen_n_o,
    output logic                  retire_o,
    output logic [1:0]            pc_mux_sel_o,
    output logic [ADDR_WIDTH-1:0] exc_pc_o,
    output logic                  save_epc_o,
    output logic                  target_valid_o,
    output logic [4:0]            cause_o,
    output logic                  sleeping_o,
    output logic                  halted_o
);

    localparam int               IDX_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_valid;
    logic [IDX_W-1:0] irq_idx;
    logic             take_trap;
    logic [4:0]       trap_cause;
    logic             mc_waiting;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_irq_prio_enc (
        .req_i   (irq_i & irq_mask_i & {NUM_IRQ{irq_gie_i}}),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    assign mc_waiting = (lsu_en_i & ~lsu_done_i) | (mc_en_i & ~mc_done_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        deassert_rf_wen_n_o = inst_valid_i;
        retire_o            = inst_valid_i & ~illegal_inst_i;
        pc_mux_sel_o        = PC_BRANCH_JUMP;
        exc_pc_o            = '0;
        save_epc_o          = 1'b0;
        target_valid_o      = 1'b0;
        cause_o             = '0;
        take_trap           = 1'b0;
        trap_cause          = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (inst_valid_i) begin
                    if (irq_valid) begin
                        take_trap  = 1'b1;
                        trap_cause = VECTORED ? (CAUSE_IRQ_VEC_BASE + 5'(irq_idx)) : CAUSE_IRQ;
                    end else if (lsu_en_i) begin
                        if (lsu_err_i) begin
                            take_trap  = 1'b1;
                            trap_cause = CAUSE_LSU_ERR;
                        end else begin
                            deassert_rf_wen_n_o = 1'b0;
                            retire_o            = 1'b0;
                            state_d             = ST_MULTI;
                        end
                    end else if (mc_en_i) begin
                        deassert_rf_wen_n_o = 1'b0;
                        retire_o            = 1'b0;
                        state_d             = ST_MULTI;
                    end else if (jump_inst_i) begin
                        retire_o = 1'b0;
                        state_d  = ST_MULTI;
                    end else if (branch_inst_i) begin
                        if (comp_result_i) begin
                            retire_o = 1'b0;
                            state_d  = ST_MULTI;
                        end
                    end else if (mret_inst_i) begin
                        pc_mux_sel_o        = PC_EPC;
                        target_valid_o      = 1'b1;
                        deassert_rf_wen_n_o = 1'b0;
                    end else if (ecall_inst_i) begin
                        take_trap  = 1'b1;
                        trap_cause = CAUSE_ECALL;
                    end else if (illegal_inst_i) begin
                        take_trap  = 1'b1;
                        trap_cause = CAUSE_ILLEGAL;
                    end else if (wfi_inst_i) begin
                        state_d = ST_SLEEP;
                    end else if (ebreak_inst_i) begin
                        retire_o = 1'b0;
                        state_d  = ST_HALT;
                    end
                end
            end
            ST_MULTI: begin
                if (inst_valid_i) begin
                    if (mc_waiting) begin
                        deassert_rf_wen_n_o = 1'b0;
                        retire_o            = 1'b0;
                        if (TIMEOUT_EN && (cnt_q >= TIMEOUT_CNT)) begin
                            take_trap  = 1'b1;
                            trap_cause = CAUSE_TIMEOUT;
                        end
                    end else begin
                        // Second cycle of a jump/taken branch presents the target.
                        target_valid_o = jump_inst_i | branch_inst_i;
                        retire_o       = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
            end
            ST_SLEEP: begin
                deassert_rf_wen_n_o = 1'b0;
                retire_o            = 1'b0;
                // Wake ignores gie; the interrupt itself is taken later from IDLE.
                if (|(irq_i & irq_mask_i)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                deassert_rf_wen_n_o = 1'b0;
                retire_o            = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (take_trap) begin
            deassert_rf_wen_n_o = 1'b0;
            retire_o            = 1'b0;
            pc_mux_sel_o        = PC_EXCEPTION;
            target_valid_o      = 1'b1;
            save_epc_o          = 1'b1;
            cause_o             = trap_cause;
            exc_pc_o            = TRAP_BASE + ADDR_WIDTH'({trap_cause, 2'b00});
            state_d             = ST_IDLE;
        end
    end

    always_comb begin
        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign cycle_counter_o = cnt_q;
    assign sleeping_o      = (state_q == ST_SLEEP);
    assign halted_o        = (state_q == ST_HALT);

endmodule
